fps_seq: RTL and testbench

- FPU phase sequencer for the floating-point datapath (F-PS side of the F-PS/F-PM pair).
- Drives the per-state microoperation enables consumed by F-PM: f2_, f4_, f5_, f6_, f7_, f8_, f9, f10_, f13.
- Also drives the two strobes strob_fp and strob2_fp, and the FPU clear _0_f.
- Chooses the next state from the F-PM condition outputs, so it is the controlling end of the F-PM interface.

---
 rtl/fps_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_fps_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fps_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fps_seq
//  Purpose  : FPU phase sequencer (F-PS side of the F-PS/F-PM pair). Walks
//             the floating-point microprogram states, producing one active
//             state enable per F-state together with two strobes per state,
//             and picks the next state from the F-PM condition outputs.
//  Ports    : __clk            system clock, rising edge
//             clm              asynchronous active-high reset
//             pufa             instruction request (level, edge-started)
//             af_sf/mw_mf/dw_df/ff_  instruction class inputs
//             g/fic/ok/nz      F-PM condition outputs
//             f2_..f10_        active-low state enables
//             f9/f13           active-high state enables
//             strob_fp/strob2_fp  first/second strobe of the current state
//             _0_f             FPU clear pulse
//             busy/fin/lerr    status: running, end pulse, loop-limit error
//  Revision : 1.0  initial release
// ============================================================================
module fps_seq #(
    parameter int STROB1_TICKS = 2,
    parameter int STROB2_TICKS = 2,
    parameter int GAP_TICKS    = 1,
    parameter int LOOP_MAX     = 40
) (
    input  logic __clk,
    input  logic clm,
    input  logic pufa,
    input  logic af_sf,
    input  logic mw_mf,
    input  logic dw_df,
    input  logic ff_,
    input  logic g,
    input  logic fic,
    input  logic ok,
    input  logic nz,
    output logic f2_,
    output logic f4_,
    output logic f5_,
    output logic f6_,
    output logic f7_,
    output logic f8_,
    output logic f9,
    output logic f10_,
    output logic f13,
    output logic strob_fp,
    output logic strob2_fp,
    output logic _0_f,
    output logic busy,
    output logic fin,
    output logic lerr
);

    localparam int c_LEN = STROB1_TICKS + STROB2_TICKS + GAP_TICKS;
    localparam int c_TW  = $clog2(c_LEN + 1);
    localparam int c_LW  = $clog2(LOOP_MAX + 1);

    // Tick boundaries inside an F-state: phase B starts at c_TICK_B,
    // phase C starts at c_TICK_C, conditions sampled at c_TICK_SMP.
    localparam logic [c_TW-1:0] c_TICK_B    = c_TW'(STROB1_TICKS);
    localparam logic [c_TW-1:0] c_TICK_C    = c_TW'(STROB1_TICKS + STROB2_TICKS);
    localparam logic [c_TW-1:0] c_TICK_SMP  = c_TW'(STROB1_TICKS + STROB2_TICKS - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_LEN - 1);
    localparam logic [c_LW-1:0] c_LOOP_LAST = c_LW'(LOOP_MAX - 1);
    localparam bit              c_NO_GAP    = (GAP_TICKS == 0);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CLR  = 4'd1,
        S_F2   = 4'd2,
        S_F4   = 4'd3,
        S_F5   = 4'd4,
        S_F6   = 4'd5,
        S_F7   = 4'd6,
        S_F8   = 4'd7,
        S_F9   = 4'd8,
        S_F10  = 4'd9,
        S_F13  = 4'd10,
        S_DONE = 4'd11
    } state_t;

    state_t            r_state, w_state_nxt;
    state_t            r_next, w_next_nxt;      // branch captured at sample tick
    state_t            w_br, w_sel_next;
    logic              r_force, w_force_nxt;    // captured branch is a forced loop exit
    logic              w_br_force, w_sel_force;
    logic [c_TW-1:0]   r_tick, w_tick_nxt;
    logic [c_LW-1:0]   r_loop, w_loop_nxt;
    logic              r_lerr, w_lerr_nxt;
    logic              r_pufa_d;
    logic              w_rise;
    logic              w_loop_full;
    logic              w_in_f;

    // The delayed copy always follows pufa, so edges seen while busy are
    // consumed and a new start needs a fresh low-then-high.
    assign w_rise      = pufa & ~r_pufa_d;
    assign w_loop_full = (r_loop == c_LOOP_LAST);

    // Branch decision from the current state and condition inputs.
    always_comb begin
        w_br       = r_state;
        w_br_force = 1'b0;
        case (r_state)
            S_F2:  w_br = S_F4;
            S_F4: begin
                if (af_sf)               w_br = S_F5;
                else if (mw_mf || dw_df) w_br = S_F8;
                else                     w_br = S_F6;
            end
            S_F5:  w_br = g ? S_F10 : S_F8;
            S_F8: begin
                if (fic) begin
                    w_br = S_F6;
                end else if (w_loop_full) begin
                    w_br       = S_F6;
                    w_br_force = 1'b1;
                end else begin
                    w_br = S_F8;
                end
            end
            S_F6:  w_br = ok ? S_F7 : S_F9;
            S_F7: begin
                if (!nz) begin
                    w_br = S_F9;
                end else if (w_loop_full) begin
                    w_br       = S_F9;
                    w_br_force = 1'b1;
                end else begin
                    w_br = S_F7;
                end
            end
            S_F9:  w_br = S_F10;
            S_F10: w_br = ff_ ? S_DONE : S_F13;
            S_F13: w_br = S_DONE;
            default: w_br = r_state;
        endcase
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_next_nxt  = r_next;
        w_force_nxt = r_force;
        w_tick_nxt  = r_tick;
        w_loop_nxt  = r_loop;
        w_lerr_nxt  = r_lerr;
        // With no gap phase the sample tick is also the last tick, so the
        // live branch is used instead of the captured one.
        w_sel_next  = c_NO_GAP ? w_br : r_next;
        w_sel_force = c_NO_GAP ? w_br_force : r_force;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_CLR;
                    w_lerr_nxt  = 1'b0;
                end
            end
            S_CLR: begin
                w_state_nxt = S_F2;
                w_tick_nxt  = '0;
                w_loop_nxt  = '0;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                if (r_tick == c_TICK_SMP) begin
                    w_next_nxt  = w_br;
                    w_force_nxt = w_br_force;
                end
                if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = w_sel_next;
                    if (w_sel_force) w_lerr_nxt = 1'b1;
                    // Pass count restarts whenever a different state is entered.
                    w_loop_nxt = (w_sel_next == r_state) ? r_loop + 1'b1 : '0;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge __clk or posedge clm) begin
        if (clm) begin
            r_state  <= S_IDLE;
            r_next   <= S_IDLE;
            r_force  <= 1'b0;
            r_tick   <= '0;
            r_loop   <= '0;
            r_lerr   <= 1'b0;
            r_pufa_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_next   <= w_next_nxt;
            r_force  <= w_force_nxt;
            r_tick   <= w_tick_nxt;
            r_loop   <= w_loop_nxt;
            r_lerr   <= w_lerr_nxt;
            r_pufa_d <= pufa;
        end
    end

    assign w_in_f = r_state inside {S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13};

    assign f2_       = (r_state != S_F2);
    assign f4_       = (r_state != S_F4);
    assign f5_       = (r_state != S_F5);
    assign f6_       = (r_state != S_F6);
    assign f7_       = (r_state != S_F7);
    assign f8_       = (r_state != S_F8);
    assign f9        = (r_state == S_F9);
    assign f10_      = (r_state != S_F10);
    assign f13       = (r_state == S_F13);
    assign strob_fp  = w_in_f && (r_tick < c_TICK_B);
    assign strob2_fp = w_in_f && (r_tick >= c_TICK_B) && (r_tick < c_TICK_C);
    assign _0_f      = (r_state == S_CLR);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign fin       = (r_state == S_DONE);
    assign lerr      = r_lerr;

endmodule
`default_nettype wire

// File: tb/tb_fps_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fps_seq
//  Purpose  : Self-checking bench for fps_seq. Instance u_a uses default
//             timing (2/2/1), instance u_b uses 1/3/0. A reference model
//             expands each instruction into its list of visited states and
//             then into an expected per-cycle output table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fps_seq;

    logic clk = 1'b0;
    logic clm;
    logic pufa_a, pufa_b;
    logic af_sf, mw_mf, dw_df, ff_, g, fic, ok, nz;

    logic a_f2_, a_f4_, a_f5_, a_f6_, a_f7_, a_f8_, a_f9, a_f10_, a_f13;
    logic a_s1, a_s2, a_clr, a_busy, a_fin, a_lerr;
    logic b_f2_, b_f4_, b_f5_, b_f6_, b_f7_, b_f8_, b_f9, b_f10_, b_f13;
    logic b_s1, b_s2, b_clr, b_busy, b_fin, b_lerr;

    always #5 clk = ~clk;

    fps_seq u_a (
        .__clk(clk), .clm(clm), .pufa(pufa_a),
        .af_sf(af_sf), .mw_mf(mw_mf), .dw_df(dw_df), .ff_(ff_),
        .g(g), .fic(fic), .ok(ok), .nz(nz),
        .f2_(a_f2_), .f4_(a_f4_), .f5_(a_f5_), .f6_(a_f6_), .f7_(a_f7_),
        .f8_(a_f8_), .f9(a_f9), .f10_(a_f10_), .f13(a_f13),
        .strob_fp(a_s1), .strob2_fp(a_s2), ._0_f(a_clr),
        .busy(a_busy), .fin(a_fin), .lerr(a_lerr)
    );

    fps_seq #(.STROB1_TICKS(1), .STROB2_TICKS(3), .GAP_TICKS(0), .LOOP_MAX(40)) u_b (
        .__clk(clk), .clm(clm), .pufa(pufa_b),
        .af_sf(af_sf), .mw_mf(mw_mf), .dw_df(dw_df), .ff_(ff_),
        .g(g), .fic(fic), .ok(ok), .nz(nz),
        .f2_(b_f2_), .f4_(b_f4_), .f5_(b_f5_), .f6_(b_f6_), .f7_(b_f7_),
        .f8_(b_f8_), .f9(b_f9), .f10_(b_f10_), .f13(b_f13),
        .strob_fp(b_s1), .strob2_fp(b_s2), ._0_f(b_clr),
        .busy(b_busy), .fin(b_fin), .lerr(b_lerr)
    );

    // Bit 5 = strob_fp, bit 4 = strob2_fp.
    wire [14:0] obs_a = {a_f2_, a_f4_, a_f5_, a_f6_, a_f7_, a_f8_, a_f9, a_f10_, a_f13,
                         a_s1, a_s2, a_clr, a_busy, a_fin, a_lerr};
    wire [14:0] obs_b = {b_f2_, b_f4_, b_f5_, b_f6_, b_f7_, b_f8_, b_f9, b_f10_, b_f13,
                         b_s1, b_s2, b_clr, b_busy, b_fin, b_lerr};

    localparam int c_LOOP = 40;

    typedef struct {
        bit af, mw, dw, ffn, g, ok;
        int n_fic;   // F8 pass index (0-based) at which fic first reads 1
        int n_nz;    // F7 pass index (0-based) at which nz first reads 0
    } ins_t;

    typedef struct {
        logic [14:0] exp;
        logic [7:0]  drv;
        int          st;
        int          idx;
    } rec_t;

    rec_t q[$];
    int   cur_s1, cur_s2, cur_len;
    bit   lerr_a_m, lerr_b_m;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // State code: 0 idle, 1 clear, 2..13 F-state number, 14 done.
    function automatic logic [14:0] mkvec(input int st, input bit s1, input bit s2, input bit le);
        return {st != 2, st != 4, st != 5, st != 6, st != 7, st != 8, st == 9, st != 10,
                st == 13, s1, s2, st == 1, (st != 0) && (st != 14), st == 14, le};
    endfunction

    function automatic logic [7:0] mkdrv(input ins_t in, input bit f, input bit n);
        return {in.af, in.mw, in.dw, in.ffn, in.g, f, in.ok, n};
    endfunction

    function automatic ins_t mk_ins(input bit af, input bit mw, input bit dw, input bit ffn,
                                    input bit gg, input bit okk, input int nf, input int nn);
        ins_t r;
        r.af = af; r.mw = mw; r.dw = dw; r.ffn = ffn; r.g = gg; r.ok = okk;
        r.n_fic = nf; r.n_nz = nn;
        return r;
    endfunction

    // Appends the cycles of one state visit; inputs are random except on the
    // sampling cycle (last cycle of the second strobe).
    task automatic add(input int st, input logic [7:0] drv, input bit le);
        rec_t r;
        if (st == 1 || st == 14) begin
            r.exp = mkvec(st, 1'b0, 1'b0, le);
            r.drv = 8'($urandom);
            r.st  = st;
            r.idx = 0;
            q.push_back(r);
        end else begin
            for (int i = 0; i < cur_len; i++) begin
                r.exp = mkvec(st, i < cur_s1, (i >= cur_s1) && (i < cur_s1 + cur_s2), le);
                r.drv = (i == cur_s1 + cur_s2 - 1) ? drv : 8'($urandom);
                r.st  = st;
                r.idx = i;
                q.push_back(r);
            end
        end
    endtask

    task automatic build(input ins_t in, output bit lm);
        int nxt;
        q.delete();
        lm = 1'b0;
        add(1, 8'h00, lm);
        add(2, mkdrv(in, 1'b0, 1'b0), lm);
        add(4, mkdrv(in, 1'b0, 1'b0), lm);
        if (in.af) begin
            add(5, mkdrv(in, 1'b0, 1'b0), lm);
            nxt = in.g ? 10 : 8;
        end else begin
            nxt = (in.mw || in.dw) ? 8 : 6;
        end
        if (nxt == 8) begin
            for (int k = 0; k < c_LOOP; k++) begin
                add(8, mkdrv(in, k >= in.n_fic, 1'b0), lm);
                if (k >= in.n_fic) break;
            end
            if (in.n_fic >= c_LOOP) lm = 1'b1;
            nxt = 6;
        end
        if (nxt == 6) begin
            add(6, mkdrv(in, 1'b0, 1'b0), lm);
            if (in.ok) begin
                for (int k = 0; k < c_LOOP; k++) begin
                    add(7, mkdrv(in, 1'b0, k < in.n_nz), lm);
                    if (k >= in.n_nz) break;
                end
                if (in.n_nz >= c_LOOP) lm = 1'b1;
            end
            nxt = 9;
        end
        if (nxt == 9) add(9, mkdrv(in, 1'b0, 1'b0), lm);
        add(10, mkdrv(in, 1'b0, 1'b0), lm);
        if (!in.ffn) add(13, mkdrv(in, 1'b0, 1'b0), lm);
        add(14, 8'h00, lm);
    endtask

    task automatic set_pufa(input bit use_b, input logic v);
        if (use_b) pufa_b = v;
        else       pufa_a = v;
    endtask

    task automatic rnd_conds();
        {af_sf, mw_mf, dw_df, ff_, g, fic, ok, nz} = 8'($urandom);
    endtask

    task automatic run(input string nm, input bit use_b, input ins_t in,
                       input bit tog, input bit abort);
        bit          lm, pre, aborted;
        int          ab;
        logic [14:0] ob;
        ab = -1;
        aborted = 1'b0;
        if (use_b) begin cur_s1 = 1; cur_s2 = 3; cur_len = 4; end
        else       begin cur_s1 = 2; cur_s2 = 2; cur_len = 5; end
        build(in, lm);
        if (abort) begin
            for (int i = 0; i < q.size(); i++)
                if (ab < 0 && q[i].st == 8 && q[i].idx == cur_s1) ab = i;
        end
        pre = use_b ? lerr_b_m : lerr_a_m;

        @(posedge clk); #1; set_pufa(use_b, 1'b0); rnd_conds();
        @(negedge clk); chk({nm, "_idle0"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, pre));
        @(posedge clk); #1; set_pufa(use_b, 1'b1); rnd_conds();
        @(negedge clk); chk({nm, "_idle1"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, pre));

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            {af_sf, mw_mf, dw_df, ff_, g, fic, ok, nz} = q[i].drv;
            if (tog && i == 3) set_pufa(use_b, 1'b0);
            if (tog && i == 5) set_pufa(use_b, 1'b1);
            @(negedge clk);
            ob = use_b ? obs_b : obs_a;
            chk($sformatf("%s_cyc%0d", nm, i), ob, q[i].exp);
            chk($sformatf("%s_ovl%0d", nm, i), ob[5] & ob[4], 1'b0);
            if (i == ab) begin
                #2 clm = 1'b1;
                #1 chk({nm, "_async_rst"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, 0));
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            lerr_a_m = 1'b0;
            lerr_b_m = 1'b0;
            repeat (3) begin
                @(posedge clk); #1; set_pufa(use_b, 1'b0); rnd_conds();
                @(negedge clk); chk({nm, "_rst_hold"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, 0));
            end
            @(posedge clk); #1; clm = 1'b0;
            repeat (3) begin
                @(posedge clk); #1; rnd_conds();
                @(negedge clk); chk({nm, "_after_rst"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, 0));
            end
        end else begin
            if (use_b) lerr_b_m = lm;
            else       lerr_a_m = lm;
            // pufa stays high: no restart is allowed.
            repeat (3) begin
                @(posedge clk); #1; rnd_conds();
                @(negedge clk); chk({nm, "_hold_hi"}, use_b ? obs_b : obs_a, mkvec(0, 0, 0, lm));
            end
        end
    endtask

    function automatic int rnd_cnt();
        return ($urandom_range(0, 6) == 0) ? 45 : int'($urandom_range(0, 5));
    endfunction

    function automatic ins_t rnd_ins();
        return mk_ins($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      rnd_cnt(), rnd_cnt());
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        clm = 1'b1;
        pufa_a = 1'b0; pufa_b = 1'b0;
        {af_sf, mw_mf, dw_df, ff_, g, fic, ok, nz} = 8'h10;
        lerr_a_m = 1'b0;
        lerr_b_m = 1'b0;
        #12;
        chk("reset_a", obs_a, mkvec(0, 0, 0, 0));
        chk("reset_b", obs_b, mkvec(0, 0, 0, 0));
        @(posedge clk); #1; clm = 1'b0;

        // af path through F5 and F8, no F13
        run("add", 1'b0, mk_ins(1, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0);
        // multiply: F8 for four passes
        run("mul", 1'b0, mk_ins(0, 1, 0, 1, 0, 0, 3, 0), 1'b0, 1'b0);
        // float add, exponent out of range, F13 taken
        run("fadd_g", 1'b0, mk_ins(1, 0, 0, 0, 1, 0, 0, 0), 1'b0, 1'b0);
        // normalise loop hits the limit; pufa toggled while busy
        run("norm_lim", 1'b0, mk_ins(0, 0, 0, 1, 0, 1, 0, 45), 1'b1, 1'b0);
        // next start clears lerr
        run("clr_lerr", 1'b0, mk_ins(0, 0, 1, 0, 0, 1, 2, 1), 1'b0, 1'b0);
        // reset during F8 phase B
        run("abort", 1'b0, mk_ins(0, 1, 0, 1, 0, 0, 10, 0), 1'b0, 1'b1);
        run("restart", 1'b0, mk_ins(0, 1, 0, 1, 0, 1, 1, 2), 1'b0, 1'b0);

        for (int n = 0; n < 12; n++)
            run($sformatf("rnd_a%0d", n), 1'b0, rnd_ins(), $urandom_range(0, 1) == 1, 1'b0);

        // short-strobe, no-gap timing
        run("b_dir", 1'b1, mk_ins(1, 0, 0, 0, 0, 1, 2, 3), 1'b0, 1'b0);
        run("b_lim", 1'b1, mk_ins(0, 1, 0, 1, 0, 0, 45, 0), 1'b1, 1'b0);
        for (int n = 0; n < 6; n++)
            run($sformatf("rnd_b%0d", n), 1'b1, rnd_ins(), $urandom_range(0, 1) == 1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
